// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 3-digit common-anode 7-segment display.
// Segment patterns are active-low {dp,g,f,e,d,c,b,a}; anode enables are active-low one-hot.
package display_pkg;

    localparam int unsigned NUM_DIGITS = 3;

    localparam logic [7:0] SEG_0      = 8'hC0;
    localparam logic [7:0] SEG_1      = 8'hF9;
    localparam logic [7:0] SEG_2      = 8'hA4;
    localparam logic [7:0] SEG_3      = 8'hB0;
    localparam logic [7:0] SEG_4      = 8'h99;
    localparam logic [7:0] SEG_5      = 8'h92;
    localparam logic [7:0] SEG_6      = 8'h82;
    localparam logic [7:0] SEG_7      = 8'hF8;
    localparam logic [7:0] SEG_8      = 8'h80;
    localparam logic [7:0] SEG_9      = 8'h90;
    localparam logic [7:0] SEG_E      = 8'h86;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam logic [7:0] SEG_CURSOR = 8'hF7;

    localparam logic [2:0] AN_NONE  = 3'b111;
    localparam logic [2:0] AN_SLOT0 = 3'b110;
    localparam logic [2:0] AN_SLOT1 = 3'b101;
    localparam logic [2:0] AN_SLOT2 = 3'b011;

    // Anode enable pattern for a scan slot index.
    function automatic logic [2:0] an_onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    an_onehot = AN_SLOT0;
            2'd1:    an_onehot = AN_SLOT1;
            2'd2:    an_onehot = AN_SLOT2;
            default: an_onehot = AN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 display 'E'.
module bcd_to_seg
    import display_pkg::*;
(
    input  logic [3:0] code,
    output logic [7:0] seg_c
);

    always_comb begin
        seg_c = SEG_E;
        case (code)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Scans a 3-digit packed-BCD value onto a multiplexed common-anode display, one input snapshot per frame.
// Optional blinking cursor on the next-entry slot is built when SCAN_BLINK_EN is defined.
module bcd_scan_display
    import display_pkg::*;
#(
    parameter int unsigned DIV          = 50000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] binary,
    input  logic [1:0]  times,
    output logic [2:0]  an,
    output logic [7:0]  seg,
    output logic        frame_start
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [11:0]      bin_s_q, bin_s_d;
    logic [1:0]       times_s_q, times_s_d;
    logic [2:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic             frame_start_q, frame_start_d;

    logic        tick_c, wrap_c, cursor_on_c;
    logic [1:0]  idx_nxt_c, times_eff_c;
    logic [11:0] bin_eff_c;
    logic [3:0]  nib_c;
    logic [7:0]  dig_seg_c;

    // Tick, next slot, and the snapshot view the next slot will be decoded from.
    always_comb begin
        tick_c      = (cnt_q == CNT_W'(DIV - 1));
        idx_nxt_c   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        wrap_c      = tick_c && (idx_nxt_c == 2'd0);
        bin_eff_c   = wrap_c ? binary : bin_s_q;
        times_eff_c = wrap_c ? times  : times_s_q;
        case (idx_nxt_c)
            2'd0:    nib_c = bin_eff_c[3:0];
            2'd1:    nib_c = bin_eff_c[7:4];
            default: nib_c = bin_eff_c[11:8];
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .code  (nib_c),
        .seg_c (dig_seg_c)
    );

`ifdef SCAN_BLINK_EN
    localparam int unsigned BLK_W = $clog2(BLINK_FRAMES) + 1;

    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_q, blink_d;

    // Blink phase toggles after every BLINK_FRAMES frame wraps.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (wrap_c) begin
            if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    // Post-update phase keeps the cursor steady across a whole frame.
    assign cursor_on_c = blink_d;
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = (BLINK_FRAMES != 0);
    assign cursor_on_c      = 1'b0;
`endif

    always_comb begin
        cnt_d         = tick_c ? '0 : cnt_q + CNT_W'(1);
        idx_d         = idx_q;
        bin_s_d       = bin_eff_c;
        times_s_d     = times_eff_c;
        an_d          = an_q;
        seg_d         = seg_q;
        frame_start_d = wrap_c;
        if (tick_c) begin
            idx_d = idx_nxt_c;
            an_d  = an_onehot(idx_nxt_c);
            if (idx_nxt_c < times_eff_c) begin
                seg_d = dig_seg_c;
            end else if ((idx_nxt_c == times_eff_c) && cursor_on_c) begin
                seg_d = SEG_CURSOR;
            end else begin
                seg_d = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= 2'd2;
            bin_s_q       <= '0;
            times_s_q     <= '0;
            an_q          <= AN_NONE;
            seg_q         <= SEG_BLANK;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            bin_s_q       <= bin_s_d;
            times_s_q     <= times_s_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display: timeline reference model driven by edge count since reset release.
module tb_bcd_scan_display;

    localparam int unsigned DIV = 4;
    localparam int unsigned BF  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] binary = '0;
    logic [1:0]  times = '0;
    logic [2:0]  an;
    logic [7:0]  seg;
    logic        frame_start;

    always #5 clk = ~clk;

    bcd_scan_display #(.DIV(DIV), .BLINK_FRAMES(BF)) dut (
        .clk         (clk),
        .rst         (rst),
        .binary      (binary),
        .times       (times),
        .an          (an),
        .seg         (seg),
        .frame_start (frame_start)
    );

    int          tests = 0;
    int          fails = 0;
    int          k = 0;
    int          wraps = 0;
    bit          phase = 1'b0;
    logic [11:0] snap_b = '0;
    logic [1:0]  snap_t = '0;
    logic [7:0]  tab [16];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, got, exp);
        end
    endtask

    // One clock edge: advance the model with the inputs present at the edge, then compare.
    task automatic step();
        logic [11:0] b_e;
        logic [1:0]  t_e;
        logic        r_e;
        logic [2:0]  e_an;
        logic [7:0]  e_seg;
        logic        e_fs;
        logic [3:0]  d;
        int          slot;
        b_e = binary;
        t_e = times;
        r_e = rst;
        @(posedge clk);
        if (r_e) begin
            k = 0; wraps = 0; phase = 1'b0; snap_b = '0; snap_t = '0;
        end else begin
            k++;
            if (k >= int'(DIV) && (k % DIV) == 0 && ((k / DIV - 1) % 3) == 0) begin
                snap_b = b_e;
                snap_t = t_e;
                wraps++;
`ifdef SCAN_BLINK_EN
                phase = ((wraps / BF) % 2) == 1;
`endif
            end
        end
        #1;
        if (r_e || k < int'(DIV)) begin
            e_an = 3'b111; e_seg = 8'hFF; e_fs = 1'b0;
        end else begin
            slot  = (k / DIV - 1) % 3;
            e_an  = 3'(~(3'b001 << slot));
            e_fs  = ((k % DIV) == 0) && (slot == 0);
            d     = snap_b[4*slot +: 4];
            if (slot < int'(snap_t))                 e_seg = tab[d];
            else if (slot == int'(snap_t) && phase)  e_seg = 8'hF7;
            else                                     e_seg = 8'hFF;
        end
        check("an", {5'b0, an}, {5'b0, e_an});
        check("seg", seg, e_seg);
        check("frame_start", {7'b0, frame_start}, {7'b0, e_fs});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        tab[0]  = 8'hC0; tab[1]  = 8'hF9; tab[2]  = 8'hA4; tab[3]  = 8'hB0;
        tab[4]  = 8'h99; tab[5]  = 8'h92; tab[6]  = 8'h82; tab[7]  = 8'hF8;
        tab[8]  = 8'h80; tab[9]  = 8'h90;
        for (int i = 10; i < 16; i++) tab[i] = 8'h86;

        // Reset and first frames showing 1,2,3
        binary = 12'h321; times = 2'd3;
        do_reset();
        run(6 * DIV);

        // Blanking with a single entered digit, long enough to cover blink phases
        binary = 12'h007; times = 2'd1;
        run(3 * DIV * 2 * BF * 2);

        // Snapshot: input changes during slot 1 appear only in the next frame
        binary = 12'h111; times = 2'd3;
        do_reset();
        run(DIV + DIV + 1);
        binary = 12'h999;
        run(6 * DIV);

        // Invalid codes show E
        binary = 12'hA0F; times = 2'd3;
        run(6 * DIV);

        // Mid-frame reset during slot 2 of the first frame
        binary = 12'h456; times = 2'd2;
        do_reset();
        run(3 * DIV + 1);
        do_reset();
        run(4 * DIV);

        // No digits entered: all blank while anodes keep scanning
        binary = 12'h789; times = 2'd0;
        run(9 * DIV);

        // Randomized input changes and occasional resets
        for (int it = 0; it < 150; it++) begin
            binary = 12'($urandom);
            times  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) do_reset();
            run(int'($urandom_range(1, 3 * DIV)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Drives a 3-digit multiplexed common-anode 7-segment display from the 12-bit packed BCD value and digit count produced by the keypad encoder (`onehot2binary`). It time-multiplexes the three digits with a programmable prescaler. Each scan frame uses one consistent snapshot of the inputs. Digits not yet entered are blanked. The block sits between the keypad encoder and the board's segment/anode pins.

## Interface
- `DIV`, 50000, clock cycles per digit slot (≥2)
- `BLINK_FRAMES`, 64, frames per cursor blink half-period (used only with `SCAN_BLINK_EN`)
- `clk`  in  1  system clock; all logic is on the rising edge
- `rst`  in  1  synchronous active-high reset
- `binary`  in  12  packed BCD: `[3:0]` first digit entered, `[7:4]` second, `[11:8]` third
- `times`  in  2  number of valid digits (0..3)
- `an`  out  3  digit enables, active-low one-hot; `an[i]` selects the digit holding `binary[4i+3:4i]`
- `seg`  out  8  segments, active-low, `{dp,g,f,e,d,c,b,a}`; dp is always 1 (off)
- `frame_start`  out  1  one-cycle pulse when a new frame begins (the snapshot is taken)

## Operation
- Prescaler `cnt` counts 0..DIV-1 and wraps. The tick is `cnt==DIV-1`.
- Scan index `idx` runs 0→1→2→0. It advances only on a tick.
- Frame wrap: any tick where the next `idx` is 0. This includes the first tick after reset.
- On a frame wrap, the snapshot registers (`bin_s`, `times_s`) load `binary` and `times`, and `frame_start` pulses.
- Digit decode for slot i:
  - if i < `times_s`: BCD pattern
  - else if i == `times_s` and blink enabled: cursor pattern
  - else: blank (0xFF)
- BCD patterns: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Codes 10–15 show E=86. Cursor (underscore) is F7.
- `times`=0 gives three blank slots; the anodes still scan.
- Input changes mid-frame do not affect the display until the next frame wrap.

## Timing
- Reset values: `cnt`=0, `idx`=2, `an`=3'b111, `seg`=8'hFF, `frame_start`=0, `bin_s`=0, `times_s`=0, blink phase=0, blink counter=0.
- With `idx` reset to 2, the first tick is a frame wrap. That tick occurs DIV cycles after `rst` deasserts and drives `an`=3'b110.
- `an`, `seg` and `frame_start` are registered. They update in the same edge as `idx` on a tick.
- On a wrap tick, `seg` for slot 0 is decoded from the snapshot value being loaded in that same edge, which is the current `binary`/`times`.
- Each slot is active for exactly DIV cycles. A frame is 3·DIV cycles, and `frame_start` has period 3·DIV.
- No dead time between slots: `an` switches from one one-hot value directly to the next.
- `rst` asserted mid-frame returns every register to its reset value on the next edge, regardless of `cnt`.

## Configuration
- `SCAN_BLINK_EN` defined:
  - A frame counter toggles the blink phase every `BLINK_FRAMES` frame wraps.
  - The cursor slot (`times_s`<3) shows F7 when the phase is 1 and FF when it is 0.
- `SCAN_BLINK_EN` undefined:
  - The cursor slot is blank.
  - The blink counter and phase register are not built, and `BLINK_FRAMES` is ignored.

## Structure
- Package `display_pkg` holds:
  - the segment constants (the digit patterns, `SEG_E`, `SEG_BLANK`, `SEG_CURSOR`)
  - `NUM_DIGITS`=3
  - the active-low anode one-hot constants
- Sub-module `bcd_to_seg` is purely combinational: 4-bit code in, 8-bit active-low pattern out, with E for codes 10–15.
- The top level holds the prescaler, scan FSM (`idx`), snapshot, blank/cursor muxing and output registers.

## Test plan
- Reset and first frame (DIV=4, `binary`=12'h321, `times`=3), release `rst`:
  - `an`=111 and `seg`=FF for 3 cycles.
  - Cycle 4: `an`=110, `seg`=F9 (digit 1), `frame_start`=1.
  - Then `an`=101, `seg`=A4 (digit 2), then `an`=011, `seg`=B0 (digit 3), each held 4 cycles.
- Blanking (`times`=1, `binary`=12'h007):
  - Slot 0 shows F8.
  - Slots 1–2 show FF; with `SCAN_BLINK_EN`, slot 1 alternates F7/FF every `BLINK_FRAMES` frames.
- Snapshot: change `binary` from 12'h111 to 12'h999 during slot 1 of a frame.
  - Slots 1–2 of that frame still show F9.
  - The next frame shows 90 on all slots.
- Invalid code (`binary`=12'hA0F, `times`=3): slots show 86, C0, 86.
- Mid-frame reset: assert `rst` during slot 2 for one cycle.
  - Next edge: `an`=111, `seg`=FF, `frame_start`=0.
  - The first new frame starts DIV cycles after release.
- `times`=0: all slots show FF. `an` still cycles 110→101→011, and `frame_start` has period 3·DIV.
